fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction fetch stage for the ARM-subset core. It holds the PC and issues word reads to instruction memory over a req/ack handshake. It presents each fetched instruction, with its PC and PC+8, to decode through a one-entry valid/ready output buffer. Decode slices instr[23:0] into the immediate extender. A branch redirect squashes in-flight and buffered fetches.

Parameters:
num_bits, 32, width of PC, addresses and instruction word
reset_pc, 32'h0000_0000, PC loaded on reset; low 2 bits must be zero

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  read request to instruction memory
imem_addr  output  num_bits  read address; word aligned; stable while imem_req=1 and imem_ack=0
imem_ack  input  1  memory accepts and completes the read this cycle; imem_rdata valid
imem_rdata  input  num_bits  instruction word, valid only when imem_ack=1
branch_valid  input  1  one-cycle redirect pulse from execute
branch_target  input  num_bits  redirect address; bits [1:0] ignored, forced to 0
instr_valid  output  1  output buffer holds an instruction
instr_ready  input  1  decode consumes the buffered instruction when instr_valid=1
instr  output  num_bits  buffered instruction word
instr_pc  output  num_bits  address of the buffered instruction
instr_pc_plus8  output  num_bits  instr_pc+8 (ARM R15 read value), combinational from instr_pc

Behaviour:
- Reset (async, immediate): pc=reset_pc, req_addr=reset_pc, state=FETCH, instr_valid=0, instr=0, instr_pc=0. imem_req=0 while reset is asserted. The first request issues in the first cycle after deassertion.
- States: FETCH, DRAIN, HOLD. imem_req=1 in FETCH and DRAIN; 0 in HOLD. imem_addr=req_addr register.
- FETCH, no branch, imem_ack=1: instr<=imem_rdata, instr_pc<=req_addr, instr_valid<=1, pc<=pc+4, go HOLD.
- FETCH, no branch, imem_ack=0: stay; req_addr unchanged.
- FETCH, branch_valid=1 with imem_ack=1: discard rdata; pc<=target, req_addr<=target; stay FETCH. New request issues next cycle.
- FETCH, branch_valid=1 with imem_ack=0: pc<=target; req_addr held; go DRAIN. The address may not change under an unacked request.
- DRAIN: hold req with old req_addr until imem_ack, then discard rdata, set req_addr<=pc, go FETCH. A further branch_valid in DRAIN updates pc only; last redirect wins.
- HOLD: when instr_ready=1, instr_valid<=0, req_addr<=pc, go FETCH. Otherwise hold all outputs stable.
- HOLD with branch_valid=1: instr_valid<=0 (flush), pc<=target, req_addr<=target, go FETCH. If instr_ready=1 in the same cycle, the handshake still counts as consumed. Redirect has priority for next-state.
- Latency: req to buffered instr is 1 cycle after ack. Peak throughput is 1 instruction per 2 cycles with zero-wait memory. At most one outstanding memory read.
- Arithmetic: pc+4 and pc+8 wrap modulo 2^num_bits, no carry out. PC bits [1:0] are always 0.
- Reset mid-request: the request is abandoned. Memory must tolerate req dropping without ack.

Test Plan:
- Reset with reset_pc=0, zero-wait memory (ack same cycle as req), instr_ready=1 -> addresses 0x0,0x4,0x8 issued on alternating cycles; instr_pc matches; instr_pc_plus8 = 0x8,0xC,0x10.
- Memory acks 3 cycles late -> imem_addr held at 0x4 for all 3 cycles; instr=rdata, instr_pc=0x4 after ack.
- instr_ready=0 for 5 cycles in HOLD -> imem_req=0; instr, instr_pc and instr_valid are stable; the next fetch issues only after ready is seen.
- branch_valid with target 0x103 while a request for 0x8 is unacked -> 0x8 held until ack and its data dropped (instr_valid stays 0); next request is 0x100.
- branch_valid in HOLD to 0x200 -> instr_valid=0 next cycle; next imem_addr is 0x200; buffered instruction never seen again.
- reset_pc=0xFFFF_FFFC -> second fetch address wraps to 0x0; instr_pc_plus8 of the first = 0x4; reset asserted mid-wait drops imem_req immediately.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, branch redirect and
// the valid/ready handoff to decode, seen from the fetch side (master).
interface fetch_stage_if #(
    parameter int num_bits = 32
);
    logic                imem_req;
    logic [num_bits-1:0] imem_addr;
    logic                imem_ack;
    logic [num_bits-1:0] imem_rdata;
    logic                branch_valid;
    logic [num_bits-1:0] branch_target;
    logic                instr_valid;
    logic                instr_ready;
    logic [num_bits-1:0] instr;
    logic [num_bits-1:0] instr_pc;
    logic [num_bits-1:0] instr_pc_plus8;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  branch_valid, branch_target,
        output instr_valid, instr, instr_pc, instr_pc_plus8,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output branch_valid, branch_target,
        input  instr_valid, instr, instr_pc, instr_pc_plus8,
        output instr_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding word reads over req/ack, and a
// one-entry output buffer to decode. Branch redirects squash in-flight work.
module fetch_stage #(
    parameter int                  num_bits = 32,
    parameter logic [num_bits-1:0] reset_pc = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

    state_t              state, state_next;
    logic [num_bits-1:0] pc, pc_next;
    logic [num_bits-1:0] req_addr, req_addr_next;
    logic [num_bits-1:0] instr_q, instr_next;
    logic [num_bits-1:0] instr_pc_q, instr_pc_next;
    logic                valid_q, valid_next;
    logic [num_bits-1:0] target;

    assign target = bus.branch_target & ~num_bits'(3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= reset_pc;
            req_addr   <= reset_pc;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            req_addr   <= req_addr_next;
            instr_q    <= instr_next;
            instr_pc_q <= instr_pc_pc_guard(instr_pc_next);
            valid_q    <= valid_next;
        end
    end

    function automatic logic [num_bits-1:0] instr_pc_pc_guard(input logic [num_bits-1:0] a);
        return a;
    endfunction

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        instr_next    = instr_q;
        instr_pc_next = instr_pc_q;
        valid_next    = valid_q;
        case (state)
            FETCH: begin
                if (bus.branch_valid) begin
                    pc_next = target;
                    // Address must not move under an unacked request.
                    if (bus.imem_ack) req_addr_next = target;
                    else              state_next    = DRAIN;
                end else if (bus.imem_ack) begin
                    instr_next    = bus.imem_rdata;
                    instr_pc_next = req_addr;
                    valid_next    = 1'b1;
                    pc_next       = pc + num_bits'(4);
                    state_next    = HOLD;
                end
            end
            DRAIN: begin
                if (bus.branch_valid) pc_next = target;
                if (bus.imem_ack) begin
                    req_addr_next = bus.branch_valid ? target : pc;
                    state_next    = FETCH;
                end
            end
            HOLD: begin
                if (bus.branch_valid) begin
                    valid_next    = 1'b0;
                    pc_next       = target;
                    req_addr_next = target;
                    state_next    = FETCH;
                end else if (bus.instr_ready) begin
                    valid_next    = 1'b0;
                    req_addr_next = pc;
                    state_next    = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    assign bus.imem_req       = (state != HOLD) && !reset;
    assign bus.imem_addr      = req_addr;
    assign bus.instr_valid    = valid_q;
    assign bus.instr          = instr_q;
    assign bus.instr_pc       = instr_pc_q;
    assign bus.instr_pc_plus8 = instr_pc_q + num_bits'(8);
endmodule
